mem_batch_ctrl: RTL and testbench
=================================

# mem_batch_ctrl

Write-side sequencer for a 4-entry register bank: one bank of four W-bit registers with a single shared load enable. It collects four words from a valid/ready stream into staging slots and fires a one-cycle bank enable with all four words presented in parallel. It then holds the batch until the downstream consumer acknowledges it. It sits between the upstream word source and the 4-word bank, and is the only driver of the bank's enable.

## Interface
Parameters:
- W, default 10: word width; must match the width of the attached bank.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, synchronous, active-low; sampled only at the rising edge of clk.
- in_valid, input, 1: upstream word valid.
- in_data, input, W: upstream word.
- in_ready, output, 1: block accepts a word this cycle.
- abort, input, 1: discard the partially filled batch.
- consume_ack, input, 1: downstream has taken the committed batch.
- mem_en, output, 1: load enable to the bank.
- mem_in0, mem_in1, mem_in2, mem_in3, output, W each: staged words, in arrival order, to bank inputs 0 to 3.
- batch_valid, output, 1: the bank holds a committed batch not yet acknowledged.
- fill_cnt, output, 2: number of words staged in the current batch.
- batch_cnt, output, 8: number of batches committed since reset, modulo 256.

## Operation
- States: FILL, COMMIT, HOLD.
- Reset (rst=0 at an edge):
  - state is FILL.
  - fill_cnt, batch_cnt, mem_in0..3 and mem_en are all 0.
  - batch_valid is 0 and in_ready is 1 from the first cycle after reset.
  - Reset overrides every other input, including mid-batch and during HOLD.
- FILL:
  - in_ready=1.
  - Accept means in_valid=1 and in_ready=1 at an edge.
  - On accept, in_data is written to slot[fill_cnt] (mem_in of that index) and fill_cnt increments.
  - An accept at fill_cnt=3 writes slot 3, sets fill_cnt to 0 and moves to COMMIT.
  - Slots not yet written in this batch keep their old contents.
- abort in FILL: fill_cnt goes to 0 and state stays FILL.
  - abort has priority over a simultaneous accept; that word is dropped and no slot is written.
  - abort in COMMIT or HOLD is ignored.
- COMMIT (exactly one cycle):
  - mem_en=1, in_ready=0.
  - batch_cnt increments at the exit edge, wrapping 255 to 0.
  - Next state is HOLD unconditionally.
- HOLD:
  - batch_valid=1, in_ready=0, mem_en=0.
  - mem_in0..3 are stable.
  - consume_ack=1 at an edge moves the block to FILL.
  - consume_ack sampled in FILL or COMMIT is ignored and not remembered.
- in_data is ignored whenever in_ready=0.

## Timing
- mem_en, batch_valid, fill_cnt, batch_cnt and mem_in0..3 are registered outputs.
- in_ready is decoded from the registered state only; it has no combinational path from in_valid or abort.
- Fourth accept at edge k:
  - mem_en=1 during cycle k+1; the bank loads at edge k+1.
  - batch_valid=1 from cycle k+2.
  - batch_cnt shows the new value from cycle k+2.
- Minimum batch period is 6 cycles: 4 accepts, then COMMIT, then 1 HOLD cycle with consume_ack already high.
- consume_ack at edge j: in_ready=1 and batch_valid=0 in cycle j+1, so the first word of the next batch can be accepted at edge j+1.
- mem_en is never high for two consecutive cycles and is never high while batch_valid=1.
- Throughput in FILL is one word per cycle; there is no bubble between accepts.

## Test plan
- Reset, then stream 4 words 0x001, 0x002, 0x003, 0x3FF back-to-back with no gaps. Required: mem_en is a single pulse in the cycle after the 4th accept; mem_in0..3 = 001/002/003/3FF; batch_valid rises the following cycle; batch_cnt=1; in_ready=0 until consume_ack.
- Accept 2 words, then assert abort together with in_valid on a 3rd word (0x155). Required: fill_cnt=0, slot 2 unchanged, no mem_en. A following 4-word batch commits cleanly with fill_cnt counting 0 to 3.
- Assert consume_ack in FILL and in COMMIT. Required: no effect. Assert consume_ack for 3 cycles in HOLD. Required: exit after the first edge; the next batch fills normally.
- Drive in_valid every cycle while in HOLD for 10 cycles. Required: no accepts and staged words unchanged; accepts resume the cycle after consume_ack.
- Pulse rst low during FILL with fill_cnt=2, and separately during HOLD. Required: all outputs return to reset values at that edge and in_ready=1 the next cycle.
- Commit 257 batches. Required: batch_cnt wraps 255 to 0 to 1, and each batch's mem_in values match its inputs.

Source files
------------

// File: rtl/mem_batch_ctrl.sv
// Purpose : gathers four stream words into staging slots, pulses a single bank
//           load enable, then holds the batch until the consumer acknowledges it.
// Latency : bank enable in the cycle after the 4th accept; batch_valid one cycle later.
// Backpres: in_ready is low from the commit cycle until consume_ack is seen in HOLD.
//
// Ports:
//   clk, rst (sync, active-low)      - clock and reset
//   in_valid/in_ready/in_data        - upstream word stream
//   abort                            - drop the partial batch (FILL only)
//   consume_ack                      - downstream took the batch (HOLD only)
//   mem_en, mem_in0..3               - bank load enable and staged words
//   batch_valid, fill_cnt, batch_cnt - status
module mem_batch_ctrl #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         abort,
    input  logic         consume_ack,
    output logic         mem_en,
    output logic [W-1:0] mem_in0,
    output logic [W-1:0] mem_in1,
    output logic [W-1:0] mem_in2,
    output logic [W-1:0] mem_in3,
    output logic         batch_valid,
    output logic [1:0]   fill_cnt,
    output logic [7:0]   batch_cnt
);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_COMMIT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0][W-1:0]   slot_q, slot_d;
    logic [1:0]          fill_cnt_q, fill_cnt_d;
    logic [7:0]          batch_cnt_q, batch_cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                batch_valid_q, batch_valid_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        fill_cnt_d    = fill_cnt_q;
        batch_cnt_d   = batch_cnt_q;
        mem_en_d      = 1'b0;
        batch_valid_d = batch_valid_q;

        unique case (state_q)
            S_FILL: begin
                // abort wins over a same-cycle word: the word is dropped
                if (abort) begin
                    fill_cnt_d = 2'd0;
                end else if (in_valid) begin
                    slot_d[fill_cnt_q] = in_data;
                    // 2-bit counter wraps 3 -> 0 on the batch-completing word
                    fill_cnt_d = fill_cnt_q + 2'd1;
                    if (fill_cnt_q == 2'd3) begin
                        state_d  = S_COMMIT;
                        mem_en_d = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                batch_cnt_d   = batch_cnt_q + 8'd1;
                batch_valid_d = 1'b1;
                state_d       = S_HOLD;
            end
            S_HOLD: begin
                if (consume_ack) begin
                    batch_valid_d = 1'b0;
                    state_d       = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_FILL;
            slot_q        <= '0;
            fill_cnt_q    <= 2'd0;
            batch_cnt_q   <= 8'd0;
            mem_en_q      <= 1'b0;
            batch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            fill_cnt_q    <= fill_cnt_d;
            batch_cnt_q   <= batch_cnt_d;
            mem_en_q      <= mem_en_d;
            batch_valid_q <= batch_valid_d;
        end
    end

    // ready depends on registered state only, never on in_valid/abort
    assign in_ready    = (state_q == S_FILL);
    assign mem_en      = mem_en_q;
    assign batch_valid = batch_valid_q;
    assign fill_cnt    = fill_cnt_q;
    assign batch_cnt   = batch_cnt_q;
    assign mem_in0     = slot_q[0];
    assign mem_in1     = slot_q[1];
    assign mem_in2     = slot_q[2];
    assign mem_in3     = slot_q[3];

endmodule

// File: tb/tb_mem_batch_ctrl.sv
// Purpose : self-checking bench for mem_batch_ctrl (vector table + corner sequences).
// Latency : outputs are checked 1 ns after each rising edge.
// Backpres: in_valid is driven regardless of in_ready to probe ignored words.
module tb_mem_batch_ctrl;

    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         abort;
    logic         consume_ack;
    logic         mem_en;
    logic [W-1:0] mem_in0, mem_in1, mem_in2, mem_in3;
    logic         batch_valid;
    logic [1:0]   fill_cnt;
    logic [7:0]   batch_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic inv_on = 1'b0;
    logic prev_en = 1'b0;

    mem_batch_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .abort       (abort),
        .consume_ack (consume_ack),
        .mem_en      (mem_en),
        .mem_in0     (mem_in0),
        .mem_in1     (mem_in1),
        .mem_in2     (mem_in2),
        .mem_in3     (mem_in3),
        .batch_valid (batch_valid),
        .fill_cnt    (fill_cnt),
        .batch_cnt   (batch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] d;
        logic         ab;
        logic         ack;
        logic         rdy;
        logic         en;
        logic         bv;
        logic [1:0]   fc;
        logic [7:0]   bc;
        logic [W-1:0] m0, m1, m2, m3;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(logic r, logic iv, logic [W-1:0] d, logic ab, logic ack,
                                logic rdy, logic en, logic bv, logic [1:0] fc, logic [7:0] bc,
                                logic [W-1:0] m0, logic [W-1:0] m1, logic [W-1:0] m2,
                                logic [W-1:0] m3);
        vec_t v;
        v.rst = r;  v.iv = iv; v.d = d; v.ab = ab; v.ack = ack;
        v.rdy = rdy; v.en = en; v.bv = bv; v.fc = fc; v.bc = bc;
        v.m0 = m0; v.m1 = m1; v.m2 = m2; v.m3 = m3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic en, input logic bv,
                             input logic [1:0] fc, input logic [7:0] bc,
                             input logic [W-1:0] m0, input logic [W-1:0] m1,
                             input logic [W-1:0] m2, input logic [W-1:0] m3);
        chk({tag, ".in_ready"},    {31'd0, in_ready},    {31'd0, rdy});
        chk({tag, ".mem_en"},      {31'd0, mem_en},      {31'd0, en});
        chk({tag, ".batch_valid"}, {31'd0, batch_valid}, {31'd0, bv});
        chk({tag, ".fill_cnt"},    {30'd0, fill_cnt},    {30'd0, fc});
        chk({tag, ".batch_cnt"},   {24'd0, batch_cnt},   {24'd0, bc});
        chk({tag, ".mem_in0"},     {22'd0, mem_in0},     {22'd0, m0});
        chk({tag, ".mem_in1"},     {22'd0, mem_in1},     {22'd0, m1});
        chk({tag, ".mem_in2"},     {22'd0, mem_in2},     {22'd0, m2});
        chk({tag, ".mem_in3"},     {22'd0, mem_in3},     {22'd0, m3});
    endtask

    // drive inputs, take one rising edge, settle
    task automatic cyc(input logic r, input logic iv, input logic [W-1:0] d,
                       input logic ab, input logic ack);
        rst = r; in_valid = iv; in_data = d; abort = ab; consume_ack = ack;
        @(posedge clk);
        #1;
    endtask

    // mem_en must never repeat on consecutive cycles nor overlap batch_valid
    always @(negedge clk) begin
        if (inv_on) begin
            chk("en_with_bv", {31'd0, mem_en & batch_valid}, 32'd0);
            chk("en_twice",   {31'd0, mem_en & prev_en},     32'd0);
            prev_en = mem_en;
        end
    end

    initial begin
        logic [W-1:0] w [4];
        logic [7:0]   exp_bc;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; consume_ack = 1'b0;

        //            rst iv d       ab ack  rdy en bv fc bc    m0      m1      m2      m3
        vecs[0]  = mk(0, 0, 10'h000, 0, 0,   1, 0, 0, 0, 0, 10'h000,10'h000,10'h000,10'h000);
        vecs[1]  = mk(1, 1, 10'h001, 0, 0,   1, 0, 0, 1, 0, 10'h001,10'h000,10'h000,10'h000);
        vecs[2]  = mk(1, 1, 10'h002, 0, 0,   1, 0, 0, 2, 0, 10'h001,10'h002,10'h000,10'h000);
        vecs[3]  = mk(1, 1, 10'h003, 0, 0,   1, 0, 0, 3, 0, 10'h001,10'h002,10'h003,10'h000);
        vecs[4]  = mk(1, 1, 10'h3FF, 0, 0,   0, 1, 0, 0, 0, 10'h001,10'h002,10'h003,10'h3FF);
        vecs[5]  = mk(1, 1, 10'h0AA, 0, 1,   0, 0, 1, 0, 1, 10'h001,10'h002,10'h003,10'h3FF);
        vecs[6]  = mk(1, 1, 10'h0AA, 0, 0,   0, 0, 1, 0, 1, 10'h001,10'h002,10'h003,10'h3FF);
        vecs[7]  = mk(1, 0, 10'h000, 0, 1,   1, 0, 0, 0, 1, 10'h001,10'h002,10'h003,10'h3FF);
        vecs[8]  = mk(1, 1, 10'h011, 0, 1,   1, 0, 0, 1, 1, 10'h011,10'h002,10'h003,10'h3FF);
        vecs[9]  = mk(1, 1, 10'h022, 0, 0,   1, 0, 0, 2, 1, 10'h011,10'h022,10'h003,10'h3FF);
        vecs[10] = mk(1, 1, 10'h155, 1, 0,   1, 0, 0, 0, 1, 10'h011,10'h022,10'h003,10'h3FF);
        vecs[11] = mk(1, 0, 10'h000, 1, 0,   1, 0, 0, 0, 1, 10'h011,10'h022,10'h003,10'h3FF);
        vecs[12] = mk(1, 1, 10'h0A1, 0, 0,   1, 0, 0, 1, 1, 10'h0A1,10'h022,10'h003,10'h3FF);
        vecs[13] = mk(1, 1, 10'h0A2, 0, 0,   1, 0, 0, 2, 1, 10'h0A1,10'h0A2,10'h003,10'h3FF);
        vecs[14] = mk(1, 1, 10'h0A3, 0, 0,   1, 0, 0, 3, 1, 10'h0A1,10'h0A2,10'h0A3,10'h3FF);
        vecs[15] = mk(1, 1, 10'h0A4, 0, 0,   0, 1, 0, 0, 1, 10'h0A1,10'h0A2,10'h0A3,10'h0A4);
        vecs[16] = mk(1, 0, 10'h000, 1, 0,   0, 0, 1, 0, 2, 10'h0A1,10'h0A2,10'h0A3,10'h0A4);
        vecs[17] = mk(1, 1, 10'h3FF, 1, 0,   0, 0, 1, 0, 2, 10'h0A1,10'h0A2,10'h0A3,10'h0A4);
        vecs[18] = mk(1, 0, 10'h000, 0, 1,   1, 0, 0, 0, 2, 10'h0A1,10'h0A2,10'h0A3,10'h0A4);
        vecs[19] = mk(1, 1, 10'h005, 0, 0,   1, 0, 0, 1, 2, 10'h005,10'h0A2,10'h0A3,10'h0A4);
        vecs[20] = mk(1, 1, 10'h006, 0, 0,   1, 0, 0, 2, 2, 10'h005,10'h006,10'h0A3,10'h0A4);
        vecs[21] = mk(0, 1, 10'h007, 0, 0,   1, 0, 0, 0, 0, 10'h000,10'h000,10'h000,10'h000);

        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ab, vecs[i].ack);
            if (i == 0) inv_on = 1'b1;
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].en, vecs[i].bv,
                      vecs[i].fc, vecs[i].bc, vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].m3);
        end

        // in_valid hammered during HOLD, then consume_ack held for 3 cycles
        cyc(1, 1, 10'h101, 0, 0);
        cyc(1, 1, 10'h102, 0, 0);
        cyc(1, 1, 10'h103, 0, 0);
        cyc(1, 1, 10'h104, 0, 0);
        check_all("hold.commit", 0, 1, 0, 0, 0, 10'h101, 10'h102, 10'h103, 10'h104);
        cyc(1, 1, 10'h3FF, 0, 0);
        check_all("hold.enter", 0, 0, 1, 0, 1, 10'h101, 10'h102, 10'h103, 10'h104);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 10'h3FF - 10'(i), 0, 0);
            check_all($sformatf("hold.busy%0d", i), 0, 0, 1, 0, 1,
                      10'h101, 10'h102, 10'h103, 10'h104);
        end
        cyc(1, 1, 10'h2EE, 0, 1);
        check_all("hold.ack1", 1, 0, 0, 0, 1, 10'h101, 10'h102, 10'h103, 10'h104);
        cyc(1, 1, 10'h201, 0, 1);
        check_all("hold.ack2", 1, 0, 0, 1, 1, 10'h201, 10'h102, 10'h103, 10'h104);
        cyc(1, 1, 10'h202, 0, 1);
        check_all("hold.ack3", 1, 0, 0, 2, 1, 10'h201, 10'h202, 10'h103, 10'h104);
        cyc(1, 1, 10'h203, 0, 0);
        cyc(1, 1, 10'h204, 0, 0);
        check_all("refill.commit", 0, 1, 0, 0, 1, 10'h201, 10'h202, 10'h203, 10'h204);
        cyc(1, 0, 10'h000, 0, 0);
        check_all("refill.hold", 0, 0, 1, 0, 2, 10'h201, 10'h202, 10'h203, 10'h204);

        // reset while holding a batch
        cyc(0, 1, 10'h3AA, 0, 0);
        check_all("rst_hold", 1, 0, 0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h000);
        cyc(1, 0, 10'h000, 0, 0);
        check_all("rst_hold.after", 1, 0, 0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h000);

        // 257 back-to-back batches at the minimum 6-cycle period
        for (int b = 1; b <= 257; b++) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = 10'((b * 4 + k) * 7);
                cyc(1, 1, w[k], 0, 0);
            end
            exp_bc = 8'(b - 1);
            check_all($sformatf("wrap%0d.commit", b), 0, 1, 0, 0, exp_bc, w[0], w[1], w[2], w[3]);
            cyc(1, 0, 10'h000, 0, 1);
            exp_bc = 8'(b);
            check_all($sformatf("wrap%0d.hold", b), 0, 0, 1, 0, exp_bc, w[0], w[1], w[2], w[3]);
            cyc(1, 0, 10'h000, 0, 1);
            check_all($sformatf("wrap%0d.free", b), 1, 0, 0, 0, exp_bc, w[0], w[1], w[2], w[3]);
        end

        cyc(1, 0, 10'h000, 0, 0);
        inv_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
